sensor_line_retimer: RTL and testbench
======================================

SENSOR_LINE_RETIMER -- requirements
Module: sensor_line_retimer

Interface
REQ-001 Parameter DATA_W, default 12, bits per pixel lane.
REQ-002 Parameter LANES, default 1, pixel lanes per beat; beat width BW = DATA_W*LANES.
REQ-003 Parameter FIFO_DEPTH, default 64, line buffer depth in beats; power of 2, >= 4.
REQ-004 Parameter LINE_DELAY, default 16, cycles from line start to first output beat; >= 1.
REQ-005 Parameter PAD_VALUE, default 0, BW-bit fill value for short lines.
REQ-006 pclk  in  1  single clock; every port is synchronous to its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_fvld / i_lvld / i_dvld  in  1 each  sensor frame / line / data valid.
REQ-009 i_data  in  BW  sensor beat; lane 0 is bits [DATA_W-1:0].
REQ-010 i_h_active  in  16  output beats per line; sampled at each accepted line start.
REQ-011 i_clr_status  in  1  single-cycle pulse; clears the sticky status bits.
REQ-012 o_fvld / o_lvld / o_dvld  out  1 each  regenerated frame / line / data valid.
REQ-013 o_data  out  BW  output beat.
REQ-014 o_ovf / o_overlap / o_short  out  1 each  sticky: FIFO overflow / dropped overlapping line / padded line.

Function
REQ-015 A write beat is i_fvld & i_lvld & i_dvld & line_accepted & wr_cnt < h_act & !full; wr_cnt is cleared at each line start.
REQ-016 A line start is an i_lvld 0->1 transition, sampled against a registered copy, while i_fvld = 1.
REQ-017 The FSM has states IDLE, DELAY and ACTIVE.
REQ-018 IDLE, line start with i_h_active != 0: latch h_act, set line_accepted, load dly_cnt = LINE_DELAY-1, go to DELAY.
REQ-019 IDLE, line start with i_h_active = 0: the line is ignored and no state change occurs.
REQ-020 DELAY: decrement dly_cnt each cycle; at 0, go to ACTIVE with out_cnt = 0.
REQ-021 ACTIVE: each cycle, emit one beat if the FIFO is non-empty (FIFO read); else emit PAD_VALUE if the write side has closed (i_lvld = 0 or i_fvld = 0); else emit nothing.
REQ-022 Each emitted beat increments out_cnt; the beat with out_cnt = h_act-1 returns the FSM to IDLE.
REQ-023 Outputs are registered: o_lvld = o_dvld = 1 exactly on emitted beats, and o_data holds the beat or PAD_VALUE.
REQ-024 Output latency: the first o_dvld occurs LINE_DELAY+1 cycles after the cycle in which the line start is sampled, provided data is available.
REQ-025 Input pixels beyond h_act per line are dropped and not flagged.
REQ-026 Any padded beat sets o_short.
REQ-027 A line start in DELAY or ACTIVE is dropped: line_accepted stays clear for it, none of its beats are written, and o_overlap is set.
REQ-028 A write attempt with full = 1 drops the beat and sets o_ovf.
REQ-029 o_fvld rises one cycle after i_fvld rises.
REQ-030 o_fvld falls on the first cycle with i_fvld = 0, FSM = IDLE and the FIFO empty; a line in progress completes, padded if needed.
REQ-031 A sampled i_fvld 0->1 edge in IDLE synchronously flushes the FIFO and clears wr_cnt; the flush takes priority over a same-cycle write.
REQ-032 i_clr_status clears all sticky bits; an event in the same cycle wins, and the bit stays set.
REQ-033 A simultaneous FIFO read and write when full is legal; the write is accepted.

Reset
REQ-034 rst_n low asynchronously forces: FSM to IDLE; all counters, FIFO pointers and flags to 0; o_fvld, o_lvld, o_dvld, o_ovf, o_overlap and o_short to 0; o_data to 0.
REQ-035 Reset asserted mid-line discards the FIFO contents; after release, output resumes only at the next accepted line start.

Structure
REQ-036 Package sensor_retimer_pkg holds the FSM state enum (IDLE, DELAY, ACTIVE), the counter width constant (16) and the helper function for pointer width, clog2(FIFO_DEPTH)+1.
REQ-037 A single sub-module, sensor_sync_fifo (BW x FIFO_DEPTH, show-ahead, with synchronous flush, full and empty), is instantiated once; all other logic is in the top level.

Verification
REQ-038 Scenario 1 -- normal line: h_active=8, 8 contiguous beats 0x001..0x008 -> o_dvld high 8 cycles starting 17 cycles after the lvld edge; data 0x001..0x008 in order; no flags set.
REQ-039 Scenario 2 -- short line: h_active=8, 5 beats then lvld falls -> 5 data beats then 3 beats of PAD_VALUE; o_short=1.
REQ-040 Scenario 3 -- long line: h_active=4, 10 input beats -> exactly 4 output beats (first 4 values); the FIFO is empty afterwards; no flags set.
REQ-041 Scenario 4 -- overlap: second lvld rise during DELAY -> second line produces no output; o_overlap=1; i_clr_status clears it to 0.
REQ-042 Scenario 5 -- overflow: FIFO_DEPTH=4, LINE_DELAY=20, h_active=8, 8 contiguous beats -> o_ovf=1; output is beats 1-4 then 4 pad beats.
REQ-043 Scenario 6 -- reset/frame: rst_n pulsed low mid-ACTIVE -> all outputs 0 immediately; fvld falling while ACTIVE -> o_fvld holds until the last beat, then falls.

Source files
------------

// File: rtl/sensor_line_retimer_pkg.sv
// Shared types and constants for the sensor line retimer: FSM states,
// counter width and FIFO pointer sizing.
package sensor_retimer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam int CNT_W = 16;

    // One extra pointer bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sensor_line_retimer_if.sv
// Sensor-side and retimed-side video signals of the line retimer,
// bundled so the bench and the retimer share one definition.
interface sensor_line_retimer_if
    import sensor_retimer_pkg::*;
#(
    parameter int BW = 12
);
    logic             i_fvld;
    logic             i_lvld;
    logic             i_dvld;
    logic [BW-1:0]    i_data;
    logic [CNT_W-1:0] i_h_active;
    logic             i_clr_status;

    logic             o_fvld;
    logic             o_lvld;
    logic             o_dvld;
    logic [BW-1:0]    o_data;
    logic             o_ovf;
    logic             o_overlap;
    logic             o_short;

    modport master (
        output i_fvld, i_lvld, i_dvld, i_data, i_h_active, i_clr_status,
        input  o_fvld, o_lvld, o_dvld, o_data, o_ovf, o_overlap, o_short
    );

    modport slave (
        input  i_fvld, i_lvld, i_dvld, i_data, i_h_active, i_clr_status,
        output o_fvld, o_lvld, o_dvld, o_data, o_ovf, o_overlap, o_short
    );

endinterface

// File: rtl/sensor_line_retimer_fifo.sv
// Show-ahead synchronous line buffer with synchronous flush; a write into a
// full FIFO is accepted when a read happens in the same cycle.
module sensor_sync_fifo
    import sensor_retimer_pkg::*;
#(
    parameter int W     = 12,
    parameter int DEPTH = 64
) (
    input  logic         pclk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          wr_ok, rd_ok;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_ok     = rd_en_i & ~empty_o & ~flush_i;
    assign wr_ok     = wr_en_i & (~full_o | rd_ok) & ~flush_i;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/sensor_line_retimer.sv
// Re-times sensor lines: each accepted line is buffered and replayed after a
// fixed delay as exactly h_active beats, padded when the sensor line is short.
module sensor_line_retimer
    import sensor_retimer_pkg::*;
#(
    parameter int                      DATA_W     = 12,
    parameter int                      LANES      = 1,
    parameter int                      FIFO_DEPTH = 64,
    parameter int                      LINE_DELAY = 16,
    parameter logic [DATA_W*LANES-1:0] PAD_VALUE  = '0
) (
    input logic                  pclk,
    input logic                  rst_n,
    sensor_line_retimer_if.slave bus
);
    localparam int BW = DATA_W * LANES;

    state_e           state_q, state_d;
    logic             fvld_q, lvld_q;
    logic             line_acc_q, line_acc_d;
    logic [CNT_W-1:0] h_act_q, h_act_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             o_fvld_q, o_fvld_d;
    logic             beat_q, beat_d;
    logic [BW-1:0]    o_data_q, o_data_d;
    logic             ovf_q, ovf_d;
    logic             overlap_q, overlap_d;
    logic             short_q, short_d;

    logic             line_start, frame_start, flush, accept, acc_eff;
    logic [CNT_W-1:0] cnt_eff, h_eff;
    logic             wr_req, wr_en, rd_en, emit, closed;
    logic             fifo_full, fifo_empty;
    logic [BW-1:0]    fifo_dout;

    // The line-start cycle already carries a beat, so acceptance, count and
    // length take effect combinationally in that same cycle.
    assign line_start  = bus.i_fvld & bus.i_lvld & ~lvld_q;
    assign frame_start = bus.i_fvld & ~fvld_q;
    assign flush       = frame_start & (state_q == IDLE);
    assign accept      = line_start & (state_q == IDLE) & (bus.i_h_active != '0);
    assign acc_eff     = line_start ? accept : line_acc_q;
    assign cnt_eff     = line_start ? '0 : wr_cnt_q;
    assign h_eff       = accept ? bus.i_h_active : h_act_q;
    assign wr_req      = bus.i_fvld & bus.i_lvld & bus.i_dvld & acc_eff &
                         (cnt_eff < h_eff) & ~flush;
    assign closed      = ~bus.i_lvld | ~bus.i_fvld;
    assign rd_en       = (state_q == ACTIVE) & ~fifo_empty;
    assign emit        = (state_q == ACTIVE) & (~fifo_empty | closed);
    assign wr_en       = wr_req & (~fifo_full | rd_en);

    sensor_sync_fifo #(
        .W     (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .wr_en_i   (wr_en),
        .wr_data_i (bus.i_data),
        .rd_en_i   (rd_en),
        .rd_data_o (fifo_dout),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        out_cnt_d  = out_cnt_q;
        h_act_d    = h_act_q;
        line_acc_d = line_start ? accept : line_acc_q;
        wr_cnt_d   = flush ? '0 : (wr_en ? cnt_eff + CNT_W'(1) : cnt_eff);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    h_act_d = bus.i_h_active;
                    dly_d   = CNT_W'(LINE_DELAY - 1);
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (dly_q == '0) begin
                    state_d   = ACTIVE;
                    out_cnt_d = '0;
                end else begin
                    dly_d = dly_q - CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (emit) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (out_cnt_q == h_act_q - CNT_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The frame stays open until the last buffered line has drained.
    always_comb begin
        o_fvld_d  = bus.i_fvld | (o_fvld_q & ~((state_q == IDLE) & fifo_empty));
        beat_d    = emit;
        o_data_d  = rd_en ? fifo_dout : (emit ? PAD_VALUE : o_data_q);
        ovf_d     = (wr_req & fifo_full & ~rd_en) | (ovf_q & ~bus.i_clr_status);
        overlap_d = (line_start & (state_q != IDLE)) | (overlap_q & ~bus.i_clr_status);
        short_d   = (emit & fifo_empty) | (short_q & ~bus.i_clr_status);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fvld_q     <= 1'b0;
            lvld_q     <= 1'b0;
            line_acc_q <= 1'b0;
            h_act_q    <= '0;
            wr_cnt_q   <= '0;
            dly_q      <= '0;
            out_cnt_q  <= '0;
            o_fvld_q   <= 1'b0;
            beat_q     <= 1'b0;
            o_data_q   <= '0;
            ovf_q      <= 1'b0;
            overlap_q  <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fvld_q     <= bus.i_fvld;
            lvld_q     <= bus.i_lvld;
            line_acc_q <= line_acc_d;
            h_act_q    <= h_act_d;
            wr_cnt_q   <= wr_cnt_d;
            dly_q      <= dly_d;
            out_cnt_q  <= out_cnt_d;
            o_fvld_q   <= o_fvld_d;
            beat_q     <= beat_d;
            o_data_q   <= o_data_d;
            ovf_q      <= ovf_d;
            overlap_q  <= overlap_d;
            short_q    <= short_d;
        end
    end

    assign bus.o_fvld    = o_fvld_q;
    assign bus.o_lvld    = beat_q;
    assign bus.o_dvld    = beat_q;
    assign bus.o_data    = o_data_q;
    assign bus.o_ovf     = ovf_q;
    assign bus.o_overlap = overlap_q;
    assign bus.o_short   = short_q;

endmodule

// File: tb/tb_sensor_line_retimer.sv
// Self-checking bench for sensor_line_retimer: a default-depth instance for
// line/frame/reset behaviour and a 4-deep instance for overflow.
module tb_sensor_line_retimer;
    localparam int             BW    = 12;
    localparam int             DLY_A = 16;
    localparam int             DLY_B = 20;
    localparam logic [BW-1:0]  PAD_A = 12'hABC;
    localparam logic [BW-1:0]  PAD_B = 12'h5A5;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    logic [BW-1:0] qa_data[$];
    int            qa_cyc[$];
    logic          qa_lv[$];
    logic [BW-1:0] qb_data[$];
    int            qb_cyc[$];

    sensor_line_retimer_if #(.BW(BW)) busA ();
    sensor_line_retimer_if #(.BW(BW)) busB ();

    sensor_line_retimer #(
        .DATA_W(12), .LANES(1), .FIFO_DEPTH(64), .LINE_DELAY(DLY_A), .PAD_VALUE(PAD_A)
    ) dutA (
        .pclk (pclk),
        .rst_n(rst_n),
        .bus  (busA.slave)
    );

    sensor_line_retimer #(
        .DATA_W(12), .LANES(1), .FIFO_DEPTH(4), .LINE_DELAY(DLY_B), .PAD_VALUE(PAD_B)
    ) dutB (
        .pclk (pclk),
        .rst_n(rst_n),
        .bus  (busB.slave)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    // Every emitted beat is logged with the cycle it became visible.
    always @(negedge pclk) begin
        if (busA.o_dvld | busA.o_lvld) begin
            qa_data.push_back(busA.o_data);
            qa_cyc.push_back(cyc);
            qa_lv.push_back(busA.o_lvld & busA.o_dvld);
        end
        if (busB.o_dvld) begin
            qb_data.push_back(busB.o_data);
            qb_cyc.push_back(cyc);
        end
    end

    task automatic idle_inputs();
        busA.i_fvld = 0; busA.i_lvld = 0; busA.i_dvld = 0; busA.i_data = '0;
        busA.i_h_active = '0; busA.i_clr_status = 0;
        busB.i_fvld = 0; busB.i_lvld = 0; busB.i_dvld = 0; busB.i_data = '0;
        busB.i_h_active = '0; busB.i_clr_status = 0;
    endtask

    task automatic pulse_clr_a();
        @(negedge pclk);
        busA.i_clr_status = 1;
        @(negedge pclk);
        busA.i_clr_status = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge pclk);
        tests++;
        if ({busA.o_fvld, busA.o_lvld, busA.o_dvld, busA.o_ovf, busA.o_overlap, busA.o_short, busA.o_data} !== 18'h0) begin
            fails++;
            $display("[TB] FAIL reset_a: got %h expected 0", {busA.o_fvld, busA.o_lvld, busA.o_dvld, busA.o_ovf, busA.o_overlap, busA.o_short, busA.o_data});
        end
        tests++;
        if ({busB.o_fvld, busB.o_lvld, busB.o_dvld, busB.o_ovf, busB.o_overlap, busB.o_short, busB.o_data} !== 18'h0) begin
            fails++;
            $display("[TB] FAIL reset_b: got %h expected 0", {busB.o_fvld, busB.o_lvld, busB.o_dvld, busB.o_ovf, busB.o_overlap, busB.o_short, busB.o_data});
        end
        rst_n = 1;
        repeat (3) @(negedge pclk);
        tests++;
        if ({busA.o_fvld, busA.o_dvld, busA.o_ovf, busA.o_overlap, busA.o_short} !== 5'b0) begin
            fails++;
            $display("[TB] FAIL post_reset_a: got %b expected 00000", {busA.o_fvld, busA.o_dvld, busA.o_ovf, busA.o_overlap, busA.o_short});
        end
    endtask

    // Fixed normal/short/long/zero-length lines followed by random lines.
    task automatic test_line_data();
        busA.i_fvld = 1;
        repeat (4) @(negedge pclk);
        for (int n = 0; n < 24; n++) begin
            int h; int len; int gap; bit rnd; logic [BW-1:0] base;
            int c0; int got; logic dv; logic [BW-1:0] d; logic exp_short;
            logic [BW-1:0] exp_d[$];
            case (n)
                0:       begin h = 8; len = 8;  gap = 0; rnd = 0; base = 12'h001; end
                1:       begin h = 8; len = 5;  gap = 0; rnd = 0; base = 12'h010; end
                2:       begin h = 4; len = 10; gap = 0; rnd = 0; base = 12'h020; end
                3:       begin h = 0; len = 6;  gap = 0; rnd = 1; base = 12'h000; end
                default: begin
                    h = $urandom_range(12, 0); len = $urandom_range(15, 1);
                    gap = $urandom_range(40, 0); rnd = 1; base = 12'h000;
                end
            endcase
            pulse_clr_a();
            qa_data.delete(); qa_cyc.delete(); qa_lv.delete(); exp_d.delete();
            got = 0;
            @(negedge pclk);
            c0 = cyc;
            busA.i_lvld = 1;
            busA.i_h_active = 16'(h);
            for (int i = 0; i < len; i++) begin
                if (i > 0) @(negedge pclk);
                dv = ($urandom_range(99, 0) >= gap);
                d  = rnd ? 12'($urandom) : base + 12'(got);
                busA.i_dvld = dv;
                busA.i_data = d;
                if (dv && got < h) exp_d.push_back(d);
                if (dv) got++;
            end
            @(negedge pclk);
            busA.i_lvld = 0; busA.i_dvld = 0; busA.i_data = '0;
            exp_short = (h > 0) && (exp_d.size() < h);
            while (exp_d.size() < h) exp_d.push_back(PAD_A);
            repeat (DLY_A + h + 6) @(negedge pclk);
            tests++;
            if (qa_data.size() !== exp_d.size()) begin
                fails++;
                $display("[TB] FAIL line%0d_count: got %0d beats expected %0d", n, qa_data.size(), exp_d.size());
            end
            for (int k = 0; k < exp_d.size() && k < qa_data.size(); k++) begin
                tests++;
                if (qa_data[k] !== exp_d[k] || qa_cyc[k] !== c0 + DLY_A + 2 + k || qa_lv[k] !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL line%0d_beat%0d: got data %h cycle %0d lvld&dvld %b expected data %h cycle %0d lvld&dvld 1",
                             n, k, qa_data[k], qa_cyc[k] - c0, qa_lv[k], exp_d[k], DLY_A + 2 + k);
                end
            end
            tests++;
            if ({busA.o_ovf, busA.o_overlap, busA.o_short} !== {2'b00, exp_short}) begin
                fails++;
                $display("[TB] FAIL line%0d_flags: got ovf/overlap/short %b expected %b", n, {busA.o_ovf, busA.o_overlap, busA.o_short}, {2'b00, exp_short});
            end
        end
    endtask

    task automatic test_overlap();
        int c0;
        logic [BW-1:0] exp_d[$];
        pulse_clr_a();
        qa_data.delete(); qa_cyc.delete(); qa_lv.delete();
        @(negedge pclk);
        c0 = cyc;
        busA.i_lvld = 1; busA.i_h_active = 16'd8;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge pclk);
            busA.i_dvld = 1; busA.i_data = 12'h031 + 12'(i);
        end
        @(negedge pclk);
        busA.i_lvld = 0; busA.i_dvld = 0;
        @(negedge pclk);
        @(negedge pclk);
        busA.i_lvld = 1; busA.i_h_active = 16'd4; busA.i_clr_status = 1;
        busA.i_dvld = 1; busA.i_data = 12'h041;
        for (int i = 1; i < 4; i++) begin
            @(negedge pclk);
            busA.i_clr_status = 0;
            busA.i_data = 12'h041 + 12'(i);
        end
        @(negedge pclk);
        busA.i_lvld = 0; busA.i_dvld = 0;
        exp_d = '{12'h031, 12'h032, 12'h033, PAD_A, PAD_A, PAD_A, PAD_A, PAD_A};
        repeat (DLY_A + 8 + 6) @(negedge pclk);
        tests++;
        if (qa_data.size() !== 8) begin
            fails++;
            $display("[TB] FAIL overlap_count: got %0d beats expected 8", qa_data.size());
        end
        for (int k = 0; k < 8 && k < qa_data.size(); k++) begin
            tests++;
            if (qa_data[k] !== exp_d[k] || qa_cyc[k] !== c0 + DLY_A + 2 + k) begin
                fails++;
                $display("[TB] FAIL overlap_beat%0d: got %h at %0d expected %h at %0d", k, qa_data[k], qa_cyc[k] - c0, exp_d[k], DLY_A + 2 + k);
            end
        end
        tests++;
        if ({busA.o_ovf, busA.o_overlap, busA.o_short} !== 3'b011) begin
            fails++;
            $display("[TB] FAIL overlap_flags: got ovf/overlap/short %b expected 011", {busA.o_ovf, busA.o_overlap, busA.o_short});
        end
        pulse_clr_a();
        @(negedge pclk);
        tests++;
        if ({busA.o_ovf, busA.o_overlap, busA.o_short} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL overlap_clear: got ovf/overlap/short %b expected 000", {busA.o_ovf, busA.o_overlap, busA.o_short});
        end
    endtask

    task automatic test_overflow();
        int c0;
        logic [BW-1:0] exp_d[$];
        busB.i_fvld = 1;
        repeat (4) @(negedge pclk);
        busB.i_clr_status = 1;
        @(negedge pclk);
        busB.i_clr_status = 0;
        qb_data.delete(); qb_cyc.delete();
        @(negedge pclk);
        c0 = cyc;
        busB.i_lvld = 1; busB.i_h_active = 16'd8;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge pclk);
            busB.i_dvld = 1; busB.i_data = 12'(i + 1);
        end
        @(negedge pclk);
        busB.i_lvld = 0; busB.i_dvld = 0;
        exp_d = '{12'h001, 12'h002, 12'h003, 12'h004, PAD_B, PAD_B, PAD_B, PAD_B};
        repeat (DLY_B + 8 + 6) @(negedge pclk);
        tests++;
        if (qb_data.size() !== 8) begin
            fails++;
            $display("[TB] FAIL ovf_count: got %0d beats expected 8", qb_data.size());
        end
        for (int k = 0; k < 8 && k < qb_data.size(); k++) begin
            tests++;
            if (qb_data[k] !== exp_d[k] || qb_cyc[k] !== c0 + DLY_B + 2 + k) begin
                fails++;
                $display("[TB] FAIL ovf_beat%0d: got %h at %0d expected %h at %0d", k, qb_data[k], qb_cyc[k] - c0, exp_d[k], DLY_B + 2 + k);
            end
        end
        tests++;
        if ({busB.o_ovf, busB.o_overlap, busB.o_short} !== 3'b101) begin
            fails++;
            $display("[TB] FAIL ovf_flags: got ovf/overlap/short %b expected 101", {busB.o_ovf, busB.o_overlap, busB.o_short});
        end
        busB.i_fvld = 0;
    endtask

    task automatic test_frame_end();
        int c0;
        qa_data.delete(); qa_cyc.delete(); qa_lv.delete();
        @(negedge pclk);
        c0 = cyc;
        busA.i_lvld = 1; busA.i_h_active = 16'd8;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge pclk);
            busA.i_dvld = 1; busA.i_data = 12'h060 + 12'(i);
        end
        @(negedge pclk);
        busA.i_lvld = 0; busA.i_dvld = 0;
        @(negedge pclk);
        @(negedge pclk);
        busA.i_fvld = 0;
        repeat (15) @(negedge pclk);
        tests++;
        if ({busA.o_fvld, busA.o_dvld} !== 2'b11 || busA.o_data !== 12'h067) begin
            fails++;
            $display("[TB] FAIL fvld_hold: got fvld/dvld %b data %h expected 11 data 067", {busA.o_fvld, busA.o_dvld}, busA.o_data);
        end
        @(negedge pclk);
        tests++;
        if ({busA.o_fvld, busA.o_dvld} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL fvld_fall: got fvld/dvld %b expected 00", {busA.o_fvld, busA.o_dvld});
        end
        tests++;
        if (qa_data.size() !== 8) begin
            fails++;
            $display("[TB] FAIL frame_end_count: got %0d beats expected 8", qa_data.size());
        end
        @(negedge pclk);
        busA.i_fvld = 1;
        #1;
        tests++;
        if (busA.o_fvld !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fvld_rise_early: got %b expected 0", busA.o_fvld);
        end
        @(negedge pclk);
        tests++;
        if (busA.o_fvld !== 1'b1) begin
            fails++;
            $display("[TB] FAIL fvld_rise: got %b expected 1", busA.o_fvld);
        end
    endtask

    task automatic test_reset_mid_line();
        int c0;
        qa_data.delete(); qa_cyc.delete(); qa_lv.delete();
        repeat (3) @(negedge pclk);
        c0 = cyc;
        busA.i_lvld = 1; busA.i_h_active = 16'd8;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge pclk);
            busA.i_dvld = 1; busA.i_data = 12'h070 + 12'(i);
        end
        @(negedge pclk);
        busA.i_lvld = 0; busA.i_dvld = 0;
        repeat (12) @(negedge pclk);
        #2;
        rst_n = 0;
        #1;
        tests++;
        if ({busA.o_fvld, busA.o_lvld, busA.o_dvld, busA.o_ovf, busA.o_overlap, busA.o_short, busA.o_data} !== 18'h0) begin
            fails++;
            $display("[TB] FAIL async_reset: got %h expected 0", {busA.o_fvld, busA.o_lvld, busA.o_dvld, busA.o_ovf, busA.o_overlap, busA.o_short, busA.o_data});
        end
        tests++;
        if (qa_data.size() !== 3) begin
            fails++;
            $display("[TB] FAIL pre_reset_beats: got %0d beats expected 3", qa_data.size());
        end
        @(posedge pclk);
        @(negedge pclk);
        rst_n = 1;
        qa_data.delete(); qa_cyc.delete(); qa_lv.delete();
        repeat (30) @(negedge pclk);
        tests++;
        if (qa_data.size() !== 0) begin
            fails++;
            $display("[TB] FAIL no_resume: got %0d beats expected 0", qa_data.size());
        end
        @(negedge pclk);
        c0 = cyc;
        busA.i_lvld = 1; busA.i_h_active = 16'd3;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge pclk);
            busA.i_dvld = 1; busA.i_data = 12'h081 + 12'(i);
        end
        @(negedge pclk);
        busA.i_lvld = 0; busA.i_dvld = 0;
        repeat (DLY_A + 3 + 6) @(negedge pclk);
        tests++;
        if (qa_data.size() !== 3) begin
            fails++;
            $display("[TB] FAIL resume_count: got %0d beats expected 3", qa_data.size());
        end
        for (int k = 0; k < 3 && k < qa_data.size(); k++) begin
            tests++;
            if (qa_data[k] !== 12'h081 + 12'(k) || qa_cyc[k] !== c0 + DLY_A + 2 + k) begin
                fails++;
                $display("[TB] FAIL resume_beat%0d: got %h at %0d expected %h at %0d", k, qa_data[k], qa_cyc[k] - c0, 12'h081 + 12'(k), DLY_A + 2 + k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_data();
        test_overlap();
        test_overflow();
        test_frame_end();
        test_reset_mid_line();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
